aes_loopback_sequencer: RTL and testbench
=========================================

# aes_loopback_sequencer

Synthesisable, emulation-ready stimulus and checker engine that replaces the behavioural AES testbench loop for Veloce runs. It generates pseudo-random keys and plaintext blocks from an on-chip LFSR, drives key load, encrypt and decrypt requests into the AES core over valid/ready handshakes, and compares each decrypted block against its source plaintext. Beyond the previous fixed 4-vector, 256-bit-key loop, it is parametrised in key width, vector count and key-refresh interval, and adds a response watchdog and pass/fail bookkeeping readable by the host.

## Interface
- KEY_W, 256: key width; legal values 128, 192, 256.
- NUM_VECTORS, 4: vectors per run, ≥1.
- KEY_EVERY, 1: load a new key every KEY_EVERY vectors, ≥1.
- SEED, 32'hACE1_2017: LFSR reset value, must be nonzero.
- TIMEOUT, 1024: max cycles waiting on any handshake before abort.
- CNT_W, 16: width of vector index and counters.
- clk  in  1  system clock, all logic on rising edge.
- resetH  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when in IDLE.
- key_valid  out  1  key_data valid.
- key_ready  in  1  core accepts key.
- key_data  out  KEY_W  key to core.
- req_valid  out  1  block request valid.
- req_ready  in  1  core accepts block.
- req_mode  out  1  0 = encrypt, 1 = decrypt.
- req_data  out  128  plaintext (encrypt) or ciphertext (decrypt).
- rsp_valid  in  1  core result valid (core has no backpressure).
- rsp_data  in  128  core result.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- err  out  1  run aborted by watchdog.
- pass_count  out  CNT_W  vectors whose decrypt matched.
- fail_count  out  CNT_W  vectors with mismatch or cipher==plaintext.
- first_fail_idx  out  CNT_W  index of first failing vector; all-ones if none.

## Operation
- LFSR: 32-bit Galois, taps 32'h8020_0003, advances exactly once per generated word; no other advancement.
- Key built from KEY_W/32 consecutive words, first word in MSBs. Plaintext from 4 words, same ordering.
- States: IDLE, GEN_KEY, LOAD_KEY, GEN_TXT, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT, CHECK, DONE.
- IDLE: start -> clear counters, first_fail_idx to all-ones, err/done to 0, vector index to 0 -> GEN_KEY.
- GEN_KEY: one word/cycle, KEY_W/32 cycles -> LOAD_KEY.
- LOAD_KEY: key_valid=1 until key_valid&key_ready cycle -> GEN_TXT.
- GEN_TXT: 4 cycles -> ENC_REQ.
- ENC_REQ: req_valid=1, req_mode=0, req_data=plaintext; on accept -> ENC_WAIT.
- ENC_WAIT: capture rsp_data as ciphertext on rsp_valid -> DEC_REQ.
- DEC_REQ: req_mode=1, req_data=ciphertext; on accept -> DEC_WAIT.
- DEC_WAIT: capture decrypted block on rsp_valid -> CHECK.
- CHECK (1 cycle): pass iff decrypted==plaintext and ciphertext!=plaintext; increment pass_count or fail_count; if first failure, record index. Then index+1; if index+1==NUM_VECTORS -> DONE; else if (index+1) mod KEY_EVERY==0 -> GEN_KEY; else GEN_TXT.
- DONE: done=1, busy=0; start -> same action as from IDLE (new run, LFSR continues, not reseeded).
- Watchdog: counter cleared on every state entry; counts in LOAD_KEY, ENC_REQ, ENC_WAIT, DEC_REQ, DEC_WAIT; reaching TIMEOUT -> err=1, drop valids, -> DONE. Counters hold values at abort.
- rsp_valid outside ENC_WAIT/DEC_WAIT ignored. start while busy ignored.
- Counters saturate at all-ones.

## Timing
- Reset: all outputs 0 except first_fail_idx all-ones; LFSR=SEED; state IDLE. Reset mid-run aborts immediately; no output glitches past reset deassertion.
- busy asserts the cycle after start sampled; deasserts on DONE entry, same edge as done rises.
- Valid outputs registered; once asserted, key_valid/req_valid and their data held stable until accepted (AXI rule), except on watchdog abort.
- rsp_valid may coincide with the request-accept cycle's next edge; zero-wait core yields minimum per-vector latency: 4 (GEN_TXT) + 1+1+1+1 (req/wait pairs) + 1 (CHECK) = 9 cycles, plus KEY_W/32+1 on key refresh.
- Counters update on CHECK exit edge; visible next cycle.

## Test plan
- Stub core with enc=dec=data XOR key[127:0], key≠0, NUM_VECTORS=4, KEY_W=256 -> done after ≤4·18 cycles, pass_count=4, fail_count=0, first_fail_idx=16'hFFFF, err=0.
- Stub flips bit 0 of decrypt result on vector 2 only -> pass_count=3, fail_count=1, first_fail_idx=2.
- KEY_W=128, KEY_EVERY=3, NUM_VECTORS=7 -> exactly 3 key handshakes (before vectors 0,3,6), key_data word order matches reference LFSR model from SEED.
- Stub holds req_ready low 50 random-length stretches, TIMEOUT=1024 -> valids/data stable while stalled, all pass; stub never asserts rsp_valid -> err=1, done=1 exactly TIMEOUT cycles after ENC_WAIT entry, pass_count=0.
- Assert resetH during DEC_WAIT of vector 1 -> all outputs return to reset values asynchronously; next start reruns from SEED with identical key_data sequence.
- start pulsed while busy and rsp_valid pulsed in IDLE -> no effect; start in DONE launches new run with counters cleared, LFSR continuing.

Source files
------------

// File: rtl/aes_loopback_sequencer.sv
// Self-contained AES loopback engine: LFSR-generated keys and plaintext are encrypted, then
// decrypted by the core, and each round trip is scored against its source block.
module aes_loopback_sequencer #(
    parameter int unsigned KEY_W       = 256,
    parameter int unsigned NUM_VECTORS = 4,
    parameter int unsigned KEY_EVERY   = 1,
    parameter logic [31:0] SEED        = 32'hACE1_2017,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             resetH,
    input  logic             start,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [KEY_W-1:0] key_data,
    output logic             req_valid,
    input  logic             req_ready,
    output logic             req_mode,
    output logic [127:0]     req_data,
    input  logic             rsp_valid,
    input  logic [127:0]     rsp_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail_idx
);

    localparam int unsigned      KeyWords = KEY_W / 32;
    localparam int unsigned      WdW      = $clog2(TIMEOUT + 1);
    localparam logic [31:0]      LfsrTaps = 32'h8020_0003;
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] CntOne   = 1;
    localparam logic [WdW-1:0]   WdOne    = 1;

    typedef enum logic [3:0] {
        StIdle, StGenKey, StLoadKey, StGenTxt, StEncReq,
        StEncWait, StDecReq, StDecWait, StCheck, StDone
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      lfsr_q, lfsr_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [127:0]     pt_q, pt_d, ct_q, ct_d, dt_q, dt_d;
    logic [3:0]       word_q, word_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [CNT_W-1:0] idx_q, idx_d, kcnt_q, kcnt_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, ffi_q, ffi_d;
    logic             err_q, err_d;
    logic             key_valid_q, key_valid_d, req_valid_q, req_valid_d;
    logic             req_mode_q, req_mode_d, busy_q, busy_d, done_q, done_d;

    logic             launch, key_hs, req_hs, wd_counting, timeout, check_pass;
    logic             last_vec, key_due;
    logic [31:0]      lfsr_next;
    logic [CNT_W:0]   idx_inc, kcnt_inc;

    assign launch      = start && (state_q == StIdle || state_q == StDone);
    assign key_hs      = key_valid_q && key_ready;
    assign req_hs      = req_valid_q && req_ready;
    assign wd_counting = state_q inside {StLoadKey, StEncReq, StEncWait, StDecReq, StDecWait};
    assign timeout     = wd_counting && (wd_q == WdW'(TIMEOUT - 1));
    assign check_pass  = (dt_q == pt_q) && (ct_q != pt_q);
    assign lfsr_next   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
    assign idx_inc     = {1'b0, idx_q} + 1'b1;
    assign kcnt_inc    = {1'b0, kcnt_q} + 1'b1;
    assign last_vec    = idx_inc == (CNT_W + 1)'(NUM_VECTORS);
    assign key_due     = kcnt_inc == (CNT_W + 1)'(KEY_EVERY);

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A completed handshake or response wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StGenKey;
            StGenKey:  if (word_q == 4'(KeyWords - 1)) state_d = StLoadKey;
            StLoadKey: if (key_hs) state_d = StGenTxt; else if (timeout) state_d = StDone;
            StGenTxt:  if (word_q == 4'd3) state_d = StEncReq;
            StEncReq:  if (req_hs) state_d = StEncWait; else if (timeout) state_d = StDone;
            StEncWait: if (rsp_valid) state_d = StDecReq; else if (timeout) state_d = StDone;
            StDecReq:  if (req_hs) state_d = StDecWait; else if (timeout) state_d = StDone;
            StDecWait: if (rsp_valid) state_d = StCheck; else if (timeout) state_d = StDone;
            StCheck: begin
                if (last_vec)     state_d = StDone;
                else if (key_due) state_d = StGenKey;
                else              state_d = StGenTxt;
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs are decoded from the next state so they leave a flop cleanly.
    always_comb begin
        key_valid_d = state_d == StLoadKey;
        req_valid_d = state_d == StEncReq || state_d == StDecReq;
        req_mode_d  = state_d == StDecReq;
        busy_d      = !(state_d == StIdle || state_d == StDone);
        done_d      = state_d == StDone;
    end

    always_comb begin
        lfsr_d = lfsr_q;
        key_d  = key_q;
        pt_d   = pt_q;
        ct_d   = ct_q;
        dt_d   = dt_q;
        word_d = word_q;
        wd_d   = wd_q;
        idx_d  = idx_q;
        kcnt_d = kcnt_q;
        pass_d = pass_q;
        fail_d = fail_q;
        ffi_d  = ffi_q;
        err_d  = err_q;

        if (state_d != state_q) begin
            wd_d   = '0;
            word_d = '0;
        end else begin
            if (wd_counting) wd_d = wd_q + WdOne;
            if (state_q == StGenKey || state_q == StGenTxt) word_d = word_q + 4'd1;
        end

        if (launch) begin
            idx_d  = '0;
            kcnt_d = '0;
            pass_d = '0;
            fail_d = '0;
            ffi_d  = '1;
            err_d  = 1'b0;
        end

        if (wd_counting && state_d == StDone) err_d = 1'b1;

        unique case (state_q)
            StGenKey: begin
                key_d  = {key_q[KEY_W-33:0], lfsr_q};
                lfsr_d = lfsr_next;
            end
            StGenTxt: begin
                pt_d   = {pt_q[95:0], lfsr_q};
                lfsr_d = lfsr_next;
            end
            StEncWait: if (rsp_valid) ct_d = rsp_data;
            StDecWait: if (rsp_valid) dt_d = rsp_data;
            StCheck: begin
                if (check_pass) begin
                    if (pass_q != CntMax) pass_d = pass_q + CntOne;
                end else begin
                    if (fail_q != CntMax) fail_d = fail_q + CntOne;
                    if (fail_q == '0) ffi_d = idx_q;
                end
                if (idx_q != CntMax) idx_d = idx_q + CntOne;
                kcnt_d = key_due ? '0 : kcnt_q + CntOne;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            lfsr_q      <= SEED;
            key_q       <= '0;
            pt_q        <= '0;
            ct_q        <= '0;
            dt_q        <= '0;
            word_q      <= '0;
            wd_q        <= '0;
            idx_q       <= '0;
            kcnt_q      <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            ffi_q       <= '1;
            err_q       <= 1'b0;
            key_valid_q <= 1'b0;
            req_valid_q <= 1'b0;
            req_mode_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            ct_q        <= ct_d;
            dt_q        <= dt_d;
            word_q      <= word_d;
            wd_q        <= wd_d;
            idx_q       <= idx_d;
            kcnt_q      <= kcnt_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            ffi_q       <= ffi_d;
            err_q       <= err_d;
            key_valid_q <= key_valid_d;
            req_valid_q <= req_valid_d;
            req_mode_q  <= req_mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign key_valid      = key_valid_q;
    assign key_data       = key_q;
    assign req_valid      = req_valid_q;
    assign req_mode       = req_mode_q;
    assign req_data       = req_mode_q ? ct_q : pt_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign pass_count     = pass_q;
    assign fail_count     = fail_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_aes_loopback_sequencer.sv
// Bench for aes_loopback_sequencer: an XOR stub core plus a scoreboard of expected keys and
// request blocks built from an independent LFSR model.
module tb_aes_loopback_sequencer;

    localparam int unsigned KeyW     = 128;
    localparam int unsigned NumVec   = 7;
    localparam int unsigned KeyEvery = 3;
    localparam int unsigned Timeout  = 48;
    localparam int unsigned KeyWords = KeyW / 32;
    localparam logic [31:0] Seed     = 32'hACE1_2017;
    localparam int unsigned MinLat   = 3 * (KeyWords + 1) + NumVec * 9;

    logic            clk = 1'b0;
    logic            resetH, start;
    logic            key_valid, key_ready, req_valid, req_ready, req_mode, rsp_valid;
    logic [KeyW-1:0] key_data;
    logic [127:0]    req_data, rsp_data;
    logic            busy, done, err;
    logic [15:0]     pass_count, fail_count, first_fail_idx;

    aes_loopback_sequencer #(
        .KEY_W      (KeyW),
        .NUM_VECTORS(NumVec),
        .KEY_EVERY  (KeyEvery),
        .SEED       (Seed),
        .TIMEOUT    (Timeout),
        .CNT_W      (16)
    ) dut (
        .clk           (clk),
        .resetH        (resetH),
        .start         (start),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .key_data      (key_data),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mode      (req_mode),
        .req_data      (req_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .pass_count    (pass_count),
        .fail_count    (fail_count),
        .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0]     model;
    logic [KeyW-1:0] exp_key[$];
    logic [127:0]    exp_enc[$];
    logic [127:0]    exp_dec[$];

    bit              stall_mode = 0, no_rsp = 0, spurious = 0;
    int              fault_abs = -1, hold_abs = -1;
    int              key_hs_n = 0, enc_n = 0, dec_n = 0, held_n = 0, stall_n = 0;
    int              key_base, enc_base;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    // Queue the expected keys and request blocks for nvec vectors, then pulse start.
    task automatic launch(input int nvec);
        logic [KeyW-1:0] k;
        logic [127:0]    p;
        exp_key.delete();
        exp_enc.delete();
        exp_dec.delete();
        k = '0;
        for (int v = 0; v < nvec; v++) begin
            if (v % KeyEvery == 0) begin
                for (int w = 0; w < KeyWords; w++) begin
                    k[KeyW-1-32*w -: 32] = model;
                    model = lfsr_step(model);
                end
                exp_key.push_back(k);
            end
            for (int w = 0; w < 4; w++) begin
                p[127-32*w -: 32] = model;
                model = lfsr_step(model);
            end
            exp_enc.push_back(p);
            exp_dec.push_back(p ^ k[127:0]);
        end
        key_base = key_hs_n;
        enc_base = enc_n;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk);
            #1 n++;
        end
        check("run_done", done, 1'b1);
    endtask

    task automatic check_end(input int p, input int f, input int ffi, input bit e, input int keys);
        check("pass_count", pass_count, p);
        check("fail_count", fail_count, f);
        check("first_fail_idx", first_fail_idx, ffi);
        check("err", err, e);
        check("busy_end", busy, 1'b0);
        check("key_handshakes", key_hs_n - key_base, keys);
    endtask

    // Stub core: result = data ^ key[127:0], optional stalls, delays, faults and withheld replies.
    initial begin
        logic            rsp_pend = 0, kv_stall = 0, rv_stall = 0, rm_prev = 0;
        int              rsp_wait = 0, stall_left = 0;
        logic [127:0]    rsp_val = '0, rd_prev = '0;
        logic [KeyW-1:0] stub_key = '0, kd_prev = '0;
        key_ready = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1 rsp_valid = 1'b0;
            if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = rsp_val;
                    rsp_pend  = 0;
                end else begin
                    rsp_wait--;
                end
            end
            if (spurious) begin
                rsp_valid = 1'b1;
                rsp_data  = {4{$urandom}};
            end
            if (stall_mode) begin
                if (stall_left > 0) begin
                    stall_left--;
                    req_ready = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    stall_left = $urandom_range(0, 5);
                    req_ready  = 1'b0;
                end else begin
                    req_ready = 1'b1;
                end
                key_ready = 1'($urandom_range(0, 1));
            end else begin
                req_ready = 1'b1;
                key_ready = 1'b1;
            end
            @(negedge clk);
            if (resetH) begin
                kv_stall = 0;
                rv_stall = 0;
                rsp_pend = 0;
            end else begin
                if (kv_stall) begin
                    check("key_valid_held", key_valid, 1'b1);
                    check("key_data_held", key_data, kd_prev);
                end
                if (rv_stall) begin
                    check("req_valid_held", req_valid, 1'b1);
                    check("req_mode_held", req_mode, rm_prev);
                    check("req_data_held", req_data, rd_prev);
                end
                kv_stall = key_valid && !key_ready;
                kd_prev  = key_data;
                rv_stall = req_valid && !req_ready;
                rm_prev  = req_mode;
                rd_prev  = req_data;
                if (rv_stall) stall_n++;
                if (key_valid && key_ready) begin
                    key_hs_n++;
                    stub_key = key_data;
                    if (exp_key.size() == 0) check("key_unexpected", 1'b1, 1'b0);
                    else check("key_data", key_data, exp_key.pop_front());
                end
                if (req_valid && req_ready) begin
                    rsp_val = req_data ^ stub_key[127:0];
                    rsp_wait = stall_mode ? $urandom_range(0, 3) : 0;
                    rsp_pend = !no_rsp;
                    if (!req_mode) begin
                        enc_n++;
                        if (exp_enc.size() == 0) check("enc_unexpected", 1'b1, 1'b0);
                        else check("enc_data", req_data, exp_enc.pop_front());
                    end else begin
                        if (exp_dec.size() == 0) check("dec_unexpected", 1'b1, 1'b0);
                        else check("dec_data", req_data, exp_dec.pop_front());
                        if (dec_n == fault_abs) rsp_val[0] = ~rsp_val[0];
                        if (dec_n == hold_abs) begin
                            rsp_pend = 0;
                            held_n++;
                        end
                        dec_n++;
                    end
                end
            end
        end
    end

    initial begin
        int n, base;
        resetH = 1'b1;
        start  = 1'b0;
        model  = Seed;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_pass", pass_count, 16'h0);
        check("rst_fail", fail_count, 16'h0);
        check("rst_ffi", first_fail_idx, 16'hFFFF);
        check("rst_key_data", key_data, '0);
        #2 resetH = 1'b0;

        // Responses while idle must be ignored.
        @(posedge clk);
        #1 spurious = 1;
        repeat (3) @(posedge clk);
        #1 spurious = 0;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
        check("idle_key_valid", key_valid, 1'b0);

        // Zero-wait core: minimum latency, all vectors pass.
        launch(NumVec);
        check("busy_rise", busy, 1'b1);
        wait_done(n);
        check("min_latency", n, MinLat);
        check_end(NumVec, 0, 16'hFFFF, 1'b0, 3);
        check("enc_count", enc_n - enc_base, NumVec);
        repeat (3) @(posedge clk);
        #1 check("done_held", done, 1'b1);

        // Stalled core, decrypt fault on vector 2, start pulsed mid-run, launched from DONE.
        stall_mode = 1;
        fault_abs  = dec_n + 2;
        base       = stall_n;
        launch(NumVec);
        check("relaunch_done", done, 1'b0);
        check("relaunch_pass", pass_count, 16'h0);
        repeat (15) @(posedge clk);
        #1 check("busy_mid", busy, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        check_end(NumVec - 1, 1, 2, 1'b0, 3);
        check("stalls_seen", stall_n > base, 1'b1);
        stall_mode = 0;
        fault_abs  = -1;

        // Core never answers: watchdog aborts from ENC_WAIT.
        no_rsp = 1;
        launch(1);
        n = 0;
        while (enc_n == enc_base && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check("wd_enc_seen", enc_n - enc_base, 1);
        n = 0;
        while (!done && n < 3 * Timeout) begin
            @(posedge clk);
            #1 n++;
        end
        check("wd_latency", n, Timeout);
        check_end(0, 0, 16'hFFFF, 1'b1, 1);
        check("wd_req_valid", req_valid, 1'b0);
        no_rsp = 0;

        // Reset while waiting on the decrypt of vector 1, then rerun from the seed.
        hold_abs = dec_n + 1;
        base     = held_n;
        launch(NumVec);
        n = 0;
        while (held_n == base && n < 500) begin
            @(posedge clk);
            #1 n++;
        end
        check("hold_reached", held_n - base, 1);
        repeat (4) @(posedge clk);
        #3 check("pre_reset_pass", pass_count, 16'h1);
        resetH = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_pass", pass_count, 16'h0);
        check("arst_ffi", first_fail_idx, 16'hFFFF);
        check("arst_req_valid", req_valid, 1'b0);
        @(posedge clk);
        #2 resetH = 1'b0;
        hold_abs = -1;
        model    = Seed;
        @(posedge clk);
        #1 launch(NumVec);
        wait_done(n);
        check("rerun_latency", n, MinLat);
        check_end(NumVec, 0, 16'hFFFF, 1'b0, 3);
        check("queues_drained", exp_key.size() + exp_enc.size() + exp_dec.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
